gb_oam_dma: RTL and testbench

OAM DMA engine behind register $FF46. It sits directly upstream of the GBC memory bus controller as a second bus initiator. On a write to $FF46 it copies 160 bytes from source page XX00-XX9F into OAM $FE00-$FE9F. While the copy runs, it asserts Busy so the CPU arbiter restricts the CPU to HRAM.

---
 rtl/gb_oam_dma_if.sv | 27 ++
 rtl/gb_oam_dma.sv | 148 ++++++++++++++
 tb/tb_gb_oam_dma.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_oam_dma_if.sv
// OAM DMA bus bundle: CPU register port, source read bus and OAM write port.
// The master modport is the DMA engine; the slave modport is its environment
// (CPU register decode, memory bus controller and OAM).
interface gb_oam_dma_if;
  logic        reg_write;
  logic [7:0]  reg_din;
  logic [7:0]  reg_dout;
  logic        busy;
  logic        src_access;
  logic [15:0] src_address;
  logic [7:0]  src_data;
  logic        src_ready;
  logic        src_data_ready;
  logic        oam_write;
  logic [7:0]  oam_address;
  logic [7:0]  oam_data;

  modport master (
    input  reg_write, reg_din, src_data, src_ready, src_data_ready,
    output reg_dout, busy, src_access, src_address, oam_write, oam_address, oam_data
  );

  modport slave (
    output reg_write, reg_din, src_data, src_ready, src_data_ready,
    input  reg_dout, busy, src_access, src_address, oam_write, oam_address, oam_data
  );
endinterface

// File: rtl/gb_oam_dma.sv
// OAM DMA engine behind $FF46: copies OamBytes bytes from source page XX00..
// into OAM, acting as a second initiator on the memory bus.
// Optional macro GB_OAM_DMA_MCYCLE_TIMING_EN locks each byte to a 4-ClkEn
// M-cycle (read issued on slot 0, OAM write on slot 3); without it the copy
// runs as fast as the bus handshake allows.
module gb_oam_dma #(
  parameter int unsigned OamBytes = 160,
  parameter logic [7:0]  EchoBase = 8'he0
) (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         clk_en_i,
  gb_oam_dma_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_WRITE
  } state_e;

  localparam logic [7:0] LastIndex = 8'(OamBytes - 1);

  state_e      state_q;
  state_e      capture_state_d;
  logic [7:0]  reg_dout_q;
  logic [7:0]  index_q;
  logic [7:0]  src_page_d;
  logic        busy_q;
  logic        src_access_q;
  logic [15:0] src_address_q;
  logic        oam_write_q;
  logic [7:0]  oam_address_q;
  logic [7:0]  oam_data_q;
`ifdef GB_OAM_DMA_MCYCLE_TIMING_EN
  logic [1:0]  slot_q;
`endif

  // Echo/OAM/IO source pages fold down by 'h20 so they read WRAM instead.
  assign src_page_d = (reg_dout_q < EchoBase) ? reg_dout_q : (reg_dout_q - 8'h20);

  // State to enter once read data is captured: straight to WRITE, or park
  // until the write slot of the M-cycle when slot timing is enabled.
  always_comb begin
    capture_state_d = S_WRITE;
`ifdef GB_OAM_DMA_MCYCLE_TIMING_EN
    if (slot_q != 2'd2) begin
      capture_state_d = S_HOLD;
    end
`endif
  end

  // Transfer FSM with registered bus/OAM outputs; everything holds while ClkEn is low.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q       <= S_IDLE;
      reg_dout_q    <= 8'hff;
      index_q       <= 8'h00;
      busy_q        <= 1'b0;
      src_access_q  <= 1'b0;
      src_address_q <= 16'h0000;
      oam_write_q   <= 1'b0;
      oam_address_q <= 8'h00;
      oam_data_q    <= 8'h00;
`ifdef GB_OAM_DMA_MCYCLE_TIMING_EN
      slot_q        <= 2'd0;
`endif
    end else if (clk_en_i) begin
`ifdef GB_OAM_DMA_MCYCLE_TIMING_EN
      // The first read of a transfer lands on slot 0.
      slot_q <= (state_q == S_START) ? 2'd0 : (slot_q + 2'd1);
`endif
      if (bus.reg_write) begin
        // A write to $FF46 (re)starts the copy from any state; an in-flight
        // read is abandoned and a write already on the OAM port completes.
        reg_dout_q   <= bus.reg_din;
        index_q      <= 8'h00;
        busy_q       <= 1'b1;
        src_access_q <= 1'b0;
        oam_write_q  <= 1'b0;
        state_q      <= S_START;
      end else begin
        case (state_q)
          S_START: begin
            src_access_q  <= 1'b1;
            src_address_q <= {src_page_d, 8'h00};
            state_q       <= S_REQ;
          end
          S_REQ: begin
            if (bus.src_ready) begin
              src_access_q <= 1'b0;
              if (bus.src_data_ready) begin
                oam_data_q    <= bus.src_data;
                oam_address_q <= index_q;
                oam_write_q   <= (capture_state_d == S_WRITE);
                state_q       <= capture_state_d;
              end else begin
                state_q <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (bus.src_data_ready) begin
              oam_data_q    <= bus.src_data;
              oam_address_q <= index_q;
              oam_write_q   <= (capture_state_d == S_WRITE);
              state_q       <= capture_state_d;
            end
          end
`ifdef GB_OAM_DMA_MCYCLE_TIMING_EN
          S_HOLD: begin
            if (slot_q == 2'd2) begin
              oam_write_q <= 1'b1;
              state_q     <= S_WRITE;
            end
          end
`endif
          S_WRITE: begin
            oam_write_q <= 1'b0;
            if (index_q == LastIndex) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              index_q       <= index_q + 8'd1;
              src_access_q  <= 1'b1;
              src_address_q <= {src_page_d, index_q + 8'd1};
              state_q       <= S_REQ;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.reg_dout    = reg_dout_q;
  assign bus.busy        = busy_q;
  assign bus.src_access  = src_access_q;
  assign bus.src_address = src_address_q;
  assign bus.oam_write   = oam_write_q;
  assign bus.oam_address = oam_address_q;
  assign bus.oam_data    = oam_data_q;

endmodule

// File: tb/tb_gb_oam_dma.sv
// Testbench for gb_oam_dma: table of whole-transfer vectors plus hand-written
// sequences for restart, restart on the final write and mid-transfer reset.
module tb_gb_oam_dma;

`ifdef GB_OAM_DMA_MCYCLE_TIMING_EN
  localparam bit Mcycle = 1'b1;
`else
  localparam bit Mcycle = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clk_en = 1'b0;

  gb_oam_dma_if bus_if ();

  gb_oam_dma dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .clk_en_i  (clk_en),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // bus responder configuration and state
  int rdy_lat = 0;
  int dat_lat = 0;
  bit xor_data = 1'b0;
  int en_period = 0;
  int req_cnt = 0;
  int dcnt = 0;
  bit pend = 1'b0;
  logic [15:0] pend_addr = 16'h0;
  int cyc = 0;
  bit last_en = 1'b0;

  // expected-transfer model
  logic [7:0]  exp_page = 8'h00;
  int          exp_idx = 0;
  int          n_writes = 0;
  int          n_en_edges = 0;
  int          rd_err = 0;
  int          wr_err = 0;
  int          stab_err = 0;
  logic [15:0] first_addr = 16'h0;
  logic [15:0] last_addr = 16'h0;
  bit          got_first = 1'b0;
  logic [7:0]  first_wr_addr = 8'h00;
  bit          got_first_wr = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic        prev_access = 1'b0;

  typedef struct {
    logic [7:0] din;
    logic [7:0] page;
    int         rdy;
    int         dat;
    bit         xd;
    int         period;
    int         edges_fast;
    int         edges_mc;
  } vec_t;

  function automatic logic [7:0] dfn(input logic [15:0] a);
    return xor_data ? (a[7:0] ^ 8'h5a) : a[7:0];
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic start_model(input logic [7:0] page);
    exp_page     = page;
    exp_idx      = 0;
    n_writes     = 0;
    n_en_edges   = 0;
    rd_err       = 0;
    wr_err       = 0;
    stab_err     = 0;
    got_first    = 1'b0;
    got_first_wr = 1'b0;
  endtask

  // One clock: drive bus responses for the coming edge, record what the edge
  // consumes, advance the responder, then settle #1 after the edge.
  task automatic step();
    logic        s_acc;
    logic        s_rdy;
    logic        s_dr;
    logic [15:0] s_addr;
    if (en_period == 0)      clk_en = 1'b0;
    else if (en_period == 1) clk_en = 1'b1;
    else                     clk_en = ((cyc % en_period) == 0);
    bus_if.src_ready      = 1'b0;
    bus_if.src_data_ready = 1'b0;
    bus_if.src_data       = 8'h00;
    if (bus_if.src_access === 1'b1) begin
      if (req_cnt >= rdy_lat) begin
        bus_if.src_ready = 1'b1;
        if (dat_lat == 0) begin
          bus_if.src_data_ready = 1'b1;
          bus_if.src_data       = dfn(bus_if.src_address);
        end
      end
    end else if (pend && dcnt >= dat_lat) begin
      bus_if.src_data_ready = 1'b1;
      bus_if.src_data       = dfn(pend_addr);
    end
    if (bus_if.src_access === 1'b1 && prev_access === 1'b1 && bus_if.src_address !== prev_addr)
      stab_err++;
    prev_access = bus_if.src_access;
    prev_addr   = bus_if.src_address;
    s_acc  = bus_if.src_access;
    s_rdy  = bus_if.src_ready;
    s_dr   = bus_if.src_data_ready;
    s_addr = bus_if.src_address;
    if (clk_en && reset_n) begin
      if (s_acc === 1'b1 && s_rdy) begin
        if (!got_first) begin
          first_addr = s_addr;
          got_first  = 1'b1;
        end
        last_addr = s_addr;
        if (s_addr !== {exp_page, 8'(exp_idx)}) rd_err++;
      end
      if (bus_if.oam_write === 1'b1) begin
        if (!got_first_wr) begin
          first_wr_addr = bus_if.oam_address;
          got_first_wr  = 1'b1;
        end
        if (bus_if.oam_address !== 8'(exp_idx) ||
            bus_if.oam_data !== dfn({exp_page, 8'(exp_idx)}))
          wr_err++;
        n_writes++;
        exp_idx++;
      end
      n_en_edges++;
    end
    last_en = clk_en;
    @(posedge clk);
    cyc++;
    if (!reset_n) begin
      pend    = 1'b0;
      req_cnt = 0;
    end else if (clk_en) begin
      if (s_acc === 1'b1) begin
        if (s_rdy) begin
          req_cnt   = 0;
          pend      = !s_dr;
          pend_addr = s_addr;
          dcnt      = 1;
        end else begin
          req_cnt++;
        end
      end else if (pend) begin
        if (s_dr) pend = 1'b0;
        else      dcnt++;
      end
    end
    #1;
  endtask

  task automatic write_reg(input logic [7:0] v);
    bus_if.reg_write = 1'b1;
    bus_if.reg_din   = v;
    do step(); while (!last_en);
    bus_if.reg_write = 1'b0;
  endtask

  task automatic run_until_idle(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if (bus_if.busy !== 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
  endtask

  vec_t vecs[7];

  initial begin
    bit to;
    bit busy_ok;
    int cyc_w;
    int exp_edges;

    vecs[0] = '{din: 8'hc1, page: 8'hc1, rdy: 0, dat: 0, xd: 1'b0, period: 1, edges_fast: 322,  edges_mc: 642};
    vecs[1] = '{din: 8'hfe, page: 8'hde, rdy: 0, dat: 0, xd: 1'b0, period: 1, edges_fast: 322,  edges_mc: 642};
    vecs[2] = '{din: 8'he0, page: 8'hc0, rdy: 0, dat: 0, xd: 1'b0, period: 1, edges_fast: 322,  edges_mc: 642};
    vecs[3] = '{din: 8'hdf, page: 8'hdf, rdy: 0, dat: 0, xd: 1'b1, period: 1, edges_fast: 322,  edges_mc: 642};
    vecs[4] = '{din: 8'hff, page: 8'hdf, rdy: 0, dat: 0, xd: 1'b0, period: 1, edges_fast: 322,  edges_mc: 642};
    vecs[5] = '{din: 8'h3a, page: 8'h3a, rdy: 2, dat: 3, xd: 1'b1, period: 1, edges_fast: 1122, edges_mc: 1282};
    vecs[6] = '{din: 8'hc1, page: 8'hc1, rdy: 0, dat: 0, xd: 1'b0, period: 3, edges_fast: 322,  edges_mc: 642};

    bus_if.reg_write      = 1'b0;
    bus_if.reg_din        = 8'h00;
    bus_if.src_ready      = 1'b0;
    bus_if.src_data_ready = 1'b0;
    bus_if.src_data       = 8'h00;
    #2;

    // reset with ClkEn low
    reset_n   = 1'b0;
    en_period = 0;
    step();
    check("rst_regdout",  {24'h0, bus_if.reg_dout}, 32'hff);
    check("rst_busy",     {31'h0, bus_if.busy}, 32'h0);
    check("rst_srcacc",   {31'h0, bus_if.src_access}, 32'h0);
    check("rst_oamwr",    {31'h0, bus_if.oam_write}, 32'h0);
    check("rst_srcaddr",  {16'h0, bus_if.src_address}, 32'h0);
    check("rst_oamaddr",  {24'h0, bus_if.oam_address}, 32'h0);
    check("rst_oamdata",  {24'h0, bus_if.oam_data}, 32'h0);
    $display("xfer reset: regdout=%02h busy=%0b", bus_if.reg_dout, bus_if.busy);
    reset_n   = 1'b1;
    en_period = 1;
    for (int i = 0; i < 3; i++) step();

    // whole-transfer vectors
    for (int v = 0; v < 7; v++) begin
      rdy_lat   = vecs[v].rdy;
      dat_lat   = vecs[v].dat;
      xor_data  = vecs[v].xd;
      en_period = vecs[v].period;
      exp_edges = Mcycle ? vecs[v].edges_mc : vecs[v].edges_fast;
      start_model(vecs[v].page);
      write_reg(vecs[v].din);
      cyc_w = cyc;
      run_until_idle(to);
      check($sformatf("v%0d_timeout", v), {31'h0, to}, 32'h0);
      check($sformatf("v%0d_writes", v), n_writes, 160);
      check($sformatf("v%0d_first", v), {16'h0, first_addr}, {16'h0, vecs[v].page, 8'h00});
      check($sformatf("v%0d_last", v), {16'h0, last_addr}, {16'h0, vecs[v].page, 8'h9f});
      check($sformatf("v%0d_rderr", v), rd_err, 0);
      check($sformatf("v%0d_wrerr", v), wr_err, 0);
      check($sformatf("v%0d_stable", v), stab_err, 0);
      check($sformatf("v%0d_regdout", v), {24'h0, bus_if.reg_dout}, {24'h0, vecs[v].din});
      check($sformatf("v%0d_edges", v), n_en_edges, exp_edges);
      check($sformatf("v%0d_span", v), cyc - cyc_w, vecs[v].period * (exp_edges - 1));
      $display("xfer din=%02h first=%04h last=%04h writes=%0d edges=%0d span=%0d",
               vecs[v].din, first_addr, last_addr, n_writes, n_en_edges, cyc - cyc_w);
      for (int i = 0; i < 4; i++) step();
    end

    rdy_lat   = 0;
    dat_lat   = 0;
    xor_data  = 1'b0;
    en_period = 1;

    // restart after 50 writes
    start_model(8'h80);
    write_reg(8'h80);
    busy_ok = 1'b1;
    to      = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (bus_if.busy !== 1'b1) busy_ok = 1'b0;
      if (n_writes == 50) begin
        to = 1'b0;
        break;
      end
      step();
    end
    check("rs_reach50", {31'h0, to}, 32'h0);
    check("rs_busy_before", {31'h0, busy_ok}, 32'h1);
    check("rs_wrerr_before", wr_err, 0);
    bus_if.reg_write = 1'b1;
    bus_if.reg_din   = 8'h90;
    step();
    bus_if.reg_write = 1'b0;
    check("rs_busy_held", {31'h0, bus_if.busy}, 32'h1);
    start_model(8'h90);
    run_until_idle(to);
    check("rs_timeout", {31'h0, to}, 32'h0);
    check("rs_writes", n_writes, 160);
    check("rs_first", {16'h0, first_addr}, 32'h9000);
    check("rs_first_oam", {24'h0, first_wr_addr}, 32'h0);
    check("rs_wrerr", wr_err, 0);
    check("rs_rderr", rd_err, 0);
    check("rs_regdout", {24'h0, bus_if.reg_dout}, 32'h90);
    $display("xfer restart 80->90: first=%04h writes=%0d", first_addr, n_writes);
    for (int i = 0; i < 4; i++) step();

    // new write on the same cycle as the final OAM write
    start_model(8'h40);
    write_reg(8'h40);
    to = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (bus_if.oam_write === 1'b1 && exp_idx == 159) begin
        to = 1'b0;
        break;
      end
      step();
    end
    check("fw_reach_last", {31'h0, to}, 32'h0);
    bus_if.reg_write = 1'b1;
    bus_if.reg_din   = 8'h41;
    step();
    bus_if.reg_write = 1'b0;
    check("fw_writes_first", n_writes, 160);
    check("fw_wrerr_first", wr_err, 0);
    check("fw_busy_held", {31'h0, bus_if.busy}, 32'h1);
    start_model(8'h41);
    n_en_edges = 1;
    run_until_idle(to);
    check("fw_timeout", {31'h0, to}, 32'h0);
    check("fw_writes", n_writes, 160);
    check("fw_first", {16'h0, first_addr}, 32'h4100);
    check("fw_last", {16'h0, last_addr}, 32'h419f);
    check("fw_wrerr", wr_err, 0);
    check("fw_edges", n_en_edges, Mcycle ? 642 : 322);
    $display("xfer back-to-back 40->41: first=%04h writes=%0d edges=%0d", first_addr, n_writes, n_en_edges);
    for (int i = 0; i < 4; i++) step();

    // reset in the middle of a transfer
    start_model(8'hc1);
    write_reg(8'hc1);
    to = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      if (n_writes == 70) begin
        to = 1'b0;
        break;
      end
      step();
    end
    check("mr_reach70", {31'h0, to}, 32'h0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("mr_busy", {31'h0, bus_if.busy}, 32'h0);
    check("mr_srcacc", {31'h0, bus_if.src_access}, 32'h0);
    check("mr_oamwr", {31'h0, bus_if.oam_write}, 32'h0);
    check("mr_regdout", {24'h0, bus_if.reg_dout}, 32'hff);
    for (int i = 0; i < 30; i++) step();
    check("mr_no_writes", n_writes, 70);
    check("mr_busy_after", {31'h0, bus_if.busy}, 32'h0);
    $display("xfer reset at byte 70: writes=%0d busy=%0b", n_writes, bus_if.busy);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
